// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (IDLE between grants, GRANT while serving)
//   NREQ, SELW  : requester count and select width (fixed at 8 / 3)
//   rr_pick     : round-robin winner search starting just after 'last'
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NREQ = 8;
    localparam int SELW = 3;

    // Scan req starting at (last+1) and wrapping. The 3-bit sum wraps 7->0 on
    // its own, so no explicit modulo is needed. With req==0 the result is
    // 'last'. Callers only use the result when some request is pending.
    function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [SELW-1:0] last);
        logic [SELW-1:0] idx;
        logic            found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last + SELW'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux_n_8to1.sv
// DW-wide 8:1 select datapath.
//   data : packed input words, word i at data[i*DW +: DW]
//   sel  : index of the word to forward
//   y    : selected word
module mux_n_8to1
    import mux_arb_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic [NREQ*DW-1:0] data,
    input  logic [SELW-1:0]    sel,
    output logic [DW-1:0]      y
);

    assign y = data[int'(sel)*DW +: DW];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one 8:1 select datapath among 8 requesters.
// The winner stays granted for up to MAX_HOLD transfers. It is released
// earlier if it drops its request. One IDLE bubble always separates grants.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request / word-valid
//   data       : packed requester words, word i at data[i*DW +: DW]
//   out_ready  : sink accepts the word this cycle
//   out_valid  : out_data is valid (granted requester still requesting)
//   out_data   : selected word, zero when not valid
//   out_src    : currently (or most recently) granted requester
//   ack        : one-hot, pulses for the requester whose word is transferred
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int NREQ     = 8,
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*DW-1:0]  data,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [SELW-1:0]     out_src,
    output logic [NREQ-1:0]     ack
);

    localparam logic [3:0] LAST_CNT = 4'(MAX_HOLD - 1);

    arb_state_t      state_q, state_d;
    logic [SELW-1:0] sel_q,   sel_d;
    logic [SELW-1:0] last_q,  last_d;
    logic [3:0]      cnt_q,   cnt_d;

    logic [DW-1:0]   mux_y;
    logic            xfer;

    mux_n_8to1 #(.DW(DW)) u_mux (
        .data (data),
        .sel  (sel_q),
        .y    (mux_y)
    );

    // NOTE: every signal driven here gets a default before the case statement.
    // Blocking assignments are correct in combinational logic, and a signal
    // missed on any path would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        out_src   = sel_q;
        out_data  = '0;
        ack       = '0;
        xfer      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = rr_pick(req, last_q);
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                out_valid = req[sel_q];
                if (out_valid) begin
                    out_data = mux_y;
                end
                xfer = out_valid && out_ready;
                if (xfer) begin
                    ack[sel_q] = 1'b1;
                    cnt_d      = cnt_q + 4'd1;
                end
                // Release when the hold budget is used up or the owner drops
                // its request. A stalled sink (out_ready low) freezes
                // everything.
                if (!req[sel_q] || (xfer && cnt_q == LAST_CNT)) begin
                    last_d  = sel_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge, whatever order the blocks run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SELW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    localparam int DW       = 1;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] data = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [0:0] out_data;
    logic [2:0] out_src;
    logic [7:0] ack;

    mux_rr_arbiter #(.NREQ(8), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the owner of the grant, how many words it has sent,
    // and who was served last. An idle gap is a cycle with no owner.
    bit m_busy;
    int m_sel, m_last, m_cnt;

    // Inputs applied on the next step, and the outputs observed in it.
    logic [7:0] cur_req = '0, cur_data = '0;
    logic       cur_ready = 1'b0;
    logic       obs_valid, obs_data;
    logic [2:0] obs_src;
    logic [7:0] obs_ack;

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_last = 7; m_cnt = 0;
    endtask

    task automatic model_update();
        if (!m_busy) begin
            for (int k = 1; k <= 8; k++) begin
                int idx = (m_last + k) % 8;
                if (cur_req[idx]) begin
                    m_sel = idx; m_cnt = 0; m_busy = 1;
                    break;
                end
            end
        end else if (!cur_req[m_sel]) begin
            m_last = m_sel; m_busy = 0;
        end else if (cur_ready) begin
            m_cnt++;
            if (m_cnt == MAX_HOLD) begin
                m_last = m_sel; m_busy = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step();
        logic       e_valid, e_data;
        logic [7:0] e_ack;
        @(negedge clk);
        req = cur_req; data = cur_data; out_ready = cur_ready;
        #1;
        e_valid = m_busy && cur_req[m_sel];
        e_data  = e_valid ? cur_data[m_sel] : 1'b0;
        e_ack   = (e_valid && cur_ready) ? (8'd1 << m_sel) : 8'd0;
        obs_valid = out_valid; obs_data = out_data; obs_src = out_src; obs_ack = ack;
        check("out_valid", 32'(obs_valid), 32'(e_valid));
        check("out_src",   32'(obs_src),   32'(m_sel));
        check("out_data",  32'(obs_data),  32'(e_data));
        check("ack",       32'(obs_ack),   32'(e_ack));
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cur_req = '0; req = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_src",   32'(out_src),   32'(0));
        check("rst_ack",       32'(ack),       32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Step until out_valid is seen; an expired budget counts as a failure.
    task automatic wait_grant(input string name, input int expect_src);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = obs_valid;
        end
        check({name, "_seen"}, 32'(seen), 32'(1));
        if (seen) check({name, "_src"}, 32'(obs_src), 32'(expect_src));
    endtask

    typedef struct {
        logic [7:0] req;
        logic [7:0] data;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_src;
        logic [7:0] exp_ack;
        logic       exp_data;
    } vec_t;

    vec_t vecs[$];
    int   order[$];
    int   acks_per[$];

    initial begin
        model_reset();
        // Single requester 0: 1-cycle latency, 4 transfers, bubble, re-grant, stall.
        vecs.push_back('{8'h01, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1});

        repeat (2) @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            cur_req = vecs[i].req; cur_data = vecs[i].data; cur_ready = vecs[i].ready;
            step();
            check($sformatf("tbl%0d_valid", i), 32'(obs_valid), 32'(vecs[i].exp_valid));
            check($sformatf("tbl%0d_src", i),   32'(obs_src),   32'(vecs[i].exp_src));
            check($sformatf("tbl%0d_ack", i),   32'(obs_ack),   32'(vecs[i].exp_ack));
            check($sformatf("tbl%0d_data", i),  32'(obs_data),  32'(vecs[i].exp_data));
        end

        // All requesting: grants rotate 0..7,0 with 4 transfers each.
        do_reset();
        cur_req = 8'hFF; cur_data = 8'hA5; cur_ready = 1'b1;
        begin
            bit prev_valid = 0;
            for (int i = 0; i < 46; i++) begin
                step();
                if (obs_ack != 0) begin
                    if (!prev_valid) begin
                        order.push_back(int'(obs_src));
                        acks_per.push_back(1);
                    end else begin
                        acks_per[$] = acks_per[$] + 1;
                    end
                end
                prev_valid = obs_valid;
            end
        end
        check("rot_count", 32'(order.size()), 32'(9));
        for (int i = 0; i < 9 && i < order.size(); i++) begin
            check($sformatf("rot%0d_src", i),  32'(order[i]),    32'(i % 8));
            check($sformatf("rot%0d_acks", i), 32'(acks_per[i]), 32'(MAX_HOLD));
        end

        // Wrap: after serving 5, req {5,0} goes to 0 first, then 5.
        do_reset();
        cur_req = 8'h20; cur_data = 8'hFF; cur_ready = 1'b1;
        repeat (5) step();
        cur_req = 8'h21;
        wait_grant("wrap_first", 0);
        repeat (3) step();
        wait_grant("wrap_second", 5);

        // Stall: grant on 3 frozen while out_ready is low.
        do_reset();
        cur_req = 8'h08; cur_data = 8'h08; cur_ready = 1'b0;
        wait_grant("stall_grant", 3);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", 32'(obs_valid), 32'(1));
            check("stall_ack",   32'(obs_ack),   32'(0));
        end
        cur_ready = 1'b1;
        for (int i = 0; i < MAX_HOLD; i++) begin
            step();
            check("stall_resume_ack", 32'(obs_ack), 32'(8'h08));
        end
        step();
        check("stall_bubble", 32'(obs_valid), 32'(0));

        // Drop: requester 2 drops after 2 transfers; pending 6 is next.
        do_reset();
        cur_req = 8'h44; cur_data = 8'h44; cur_ready = 1'b1;
        wait_grant("drop_grant", 2);
        step();
        cur_req = 8'h40;
        step();
        check("drop_valid", 32'(obs_valid), 32'(0));
        check("drop_ack",   32'(obs_ack),   32'(0));
        wait_grant("drop_next", 6);

        // Reset mid-grant: outputs clear at once, then requester 0 has priority.
        do_reset();
        cur_req = 8'h01; cur_data = 8'h01; cur_ready = 1'b1;
        wait_grant("mid_grant", 0);
        step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_ack",   32'(ack),       32'(0));
        check("mid_rst_data",  32'(out_data),  32'(0));
        check("mid_rst_src",   32'(out_src),   32'(0));
        model_reset();
        cur_req = '0; req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cur_req = 8'h81;
        wait_grant("post_rst", 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) cur_req = 8'($urandom);
            cur_data  = 8'($urandom);
            cur_ready = ($urandom_range(0, 3) != 0);
            step();
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
